// File: rtl/issue_scoreboard.sv
// Issue-stage scoreboard: register/flag/PC write tracking and unit occupancy.
// Optional SB_WB_BYPASS_EN lets same-cycle writeback releases clear hazards.
module issue_scoreboard #(
   parameter int MUL_LAT = 4,
   parameter int FP_LAT  = 6
) (
   input  logic        CLK,
   input  logic        Reset,
   input  logic        IssueI,
   input  logic [3:0]  RA1I,
   input  logic [3:0]  RA2I,
   input  logic [3:0]  WA3I,
   input  logic        ALUSrcI,
   input  logic        RegWI,
   input  logic        NoWriteI,
   input  logic [3:0]  FlagWI,
   input  logic [3:0]  CondI,
   input  logic        MULSI,
   input  logic        FPSI,
   input  logic        PCSI,
   input  logic        Flush,
   input  logic        WBValid,
   input  logic [3:0]  WBWA3,
   input  logic        WBRegW,
   input  logic        WBFlagW,
   output logic        IssueGo,
   output logic        StallI,
   output logic [15:0] BusyMask,
   output logic        FlagsBusy,
   output logic        PCPending,
   output logic        MulBusy,
   output logic        FpBusy
);

   localparam logic [3:0] MUL_INIT = 4'(MUL_LAT);
   localparam logic [3:0] FP_INIT  = 4'(FP_LAT);

   logic [15:0] busy;
   logic        flags_busy;
   logic        pc_pend;
   logic [3:0]  mul_cnt;
   logic [3:0]  fp_cnt;

   logic        wr;
   logic        flag_w;
   logic        needs_flags;
   logic [15:0] rel_mask;
   logic        rel_pc;
   logic        rel_flags;
   logic [15:0] set_mask;
   logic        set_pc;
   logic        set_flags;
   logic [15:0] chk_busy;
   logic        chk_flags;
   logic        chk_pc;
   logic        raw1;
   logic        raw2;
   logic        waw;
   logic        haz_flags;
   logic        hazard;

   assign wr          = RegWI & ~NoWriteI;
   assign flag_w      = |FlagWI;
   assign needs_flags = (CondI != 4'b1110);

   // Writeback release decode; R15 maps onto the PC-pending bit
   always_comb begin
      rel_mask = '0;
      if (WBValid && WBRegW && (WBWA3 != 4'hF))
         rel_mask[WBWA3] = 1'b1;
   end

   assign rel_pc    = WBValid & WBRegW & (WBWA3 == 4'hF);
   assign rel_flags = WBValid & WBFlagW;

`ifdef SB_WB_BYPASS_EN
   assign chk_busy  = busy & ~rel_mask;
   assign chk_flags = flags_busy & ~rel_flags;
   assign chk_pc    = pc_pend & ~rel_pc;
`else
   assign chk_busy  = busy;
   assign chk_flags = flags_busy;
   assign chk_pc    = pc_pend;
`endif

   assign raw1      = (RA1I != 4'hF) & chk_busy[RA1I];
   assign raw2      = ~ALUSrcI & (RA2I != 4'hF) & chk_busy[RA2I];
   assign waw       = wr & chk_busy[WA3I];
   assign haz_flags = chk_flags & (needs_flags | flag_w);

   assign hazard = raw1 | raw2 | waw | haz_flags | chk_pc
                 | (MULSI & MulBusy) | (FPSI & FpBusy);

   assign IssueGo = IssueI & ~hazard & ~Flush;
   assign StallI  = IssueI & hazard & ~Flush;

   always_comb begin
      set_mask = '0;
      if (IssueGo && wr && (WA3I != 4'hF))
         set_mask[WA3I] = 1'b1;
   end

   assign set_pc    = IssueGo & ((wr & (WA3I == 4'hF)) | PCSI);
   assign set_flags = IssueGo & flag_w;

   // Clear first, then set: a new writer wins over a same-edge release
   always_ff @(posedge CLK) begin
      if (Reset) begin
         busy       <= '0;
         flags_busy <= 1'b0;
         pc_pend    <= 1'b0;
         mul_cnt    <= '0;
         fp_cnt     <= '0;
      end else begin
         busy       <= (busy & ~rel_mask) | set_mask;
         flags_busy <= (flags_busy & ~rel_flags) | set_flags;
         pc_pend    <= (pc_pend & ~rel_pc) | set_pc;
         if (IssueGo && MULSI)
            mul_cnt <= MUL_INIT;
         else if (mul_cnt != '0)
            mul_cnt <= mul_cnt - 4'd1;
         if (IssueGo && FPSI)
            fp_cnt <= FP_INIT;
         else if (fp_cnt != '0)
            fp_cnt <= fp_cnt - 4'd1;
      end
   end

   assign BusyMask  = busy;
   assign FlagsBusy = flags_busy;
   assign PCPending = pc_pend;
   assign MulBusy   = (mul_cnt != '0);
   assign FpBusy    = (fp_cnt != '0);

endmodule
